wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter_pkg.sv | 15 +
 rtl/wb_master_arbiter_rr_arbiter.sv | 44 ++++
 rtl/wb_master_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_master_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared state encodings and default sizing for the Wishbone master arbiter.
package wb_master_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_master_arbiter_rr_arbiter.sv
// Combinational one-hot picker. Round-robin from last_grant+1 by default;
// WB_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index wins).
module rr_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int LGW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LGW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LGW-1:0]     gnt_idx,
  output logic               valid
);

`ifdef WB_ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
`ifdef WB_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = LGW'(i);
        valid   = 1'b1;
      end
    end
`else
    // Scan farthest-first so the nearest requester after last_grant wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % NUM_REQ]) begin
        gnt_idx = LGW'((int'(last_grant) + i) % NUM_REQ);
        valid   = 1'b1;
      end
    end
`endif
    if (valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Multi-requester front end for a single Wishbone master command port.
// Arbitration mode selected by WB_ARB_FIXED_PRIORITY_EN (see rr_arbiter).
//   state     | meaning
//   IDLE      | waiting for a request while the master interface is quiet
//   ISSUE     | m_start_o high for one cycle with latched command
//   WAIT_BUSY | waiting for the master interface to report active
//   WAIT_DONE | waiting for the master interface to go idle again
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int aw      = DEF_AW,
  parameter int dw      = DEF_DW
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*aw-1:0]  req_adr_i,
  input  logic [NUM_REQ*4-1:0]   req_sel_i,
  input  logic [NUM_REQ-1:0]     req_we_i,
  input  logic [NUM_REQ*dw-1:0]  req_dat_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [dw-1:0]          rsp_dat_o,
  output logic                   busy_o,
  output logic                   m_start_o,
  output logic [aw-1:0]          m_address_o,
  output logic [3:0]             m_selection_o,
  output logic                   m_write_o,
  output logic [dw-1:0]          m_data_wr_o,
  input  logic [dw-1:0]          m_data_rd_i,
  input  logic                   m_active_i
);

  localparam int LGW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [LGW-1:0]     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] pick_gnt, gnt_d, done_d;
  logic [LGW-1:0]     pick_idx;
  logic               pick_valid;
  logic               start_d, we_d;
  logic [aw-1:0]      adr_d;
  logic [3:0]         sel_d;
  logic [dw-1:0]      wdat_d, rsp_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req        (req_i),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_o;
    done_d       = '0;
    start_d      = 1'b0;
    adr_d        = m_address_o;
    sel_d        = m_selection_o;
    we_d         = m_write_o;
    wdat_d       = m_data_wr_o;
    rsp_d        = rsp_dat_o;
    unique case (state_q)
      IDLE: begin
        // Foreign traffic on the master port blocks new grants.
        if (pick_valid && !m_active_i) begin
          gnt_d        = pick_gnt;
          last_grant_d = pick_idx;
          adr_d        = req_adr_i[int'(pick_idx)*aw +: aw];
          sel_d        = req_sel_i[int'(pick_idx)*4 +: 4];
          we_d         = req_we_i[pick_idx];
          wdat_d       = req_dat_i[int'(pick_idx)*dw +: dw];
          start_d      = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (m_active_i) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!m_active_i) begin
          if (!m_write_o) rsp_d = m_data_rd_i;
          done_d  = gnt_o;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= LGW'(NUM_REQ - 1);
      gnt_o         <= '0;
      done_o        <= '0;
      rsp_dat_o     <= '0;
      busy_o        <= 1'b0;
      m_start_o     <= 1'b0;
      m_address_o   <= '0;
      m_selection_o <= '0;
      m_write_o     <= 1'b0;
      m_data_wr_o   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_o         <= gnt_d;
      done_o        <= done_d;
      rsp_dat_o     <= rsp_d;
      busy_o        <= (state_d != IDLE);
      m_start_o     <= start_d;
      m_address_o   <= adr_d;
      m_selection_o <= sel_d;
      m_write_o     <= we_d;
      m_data_wr_o   <= wdat_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter; honours WB_ARB_FIXED_PRIORITY_EN.
module tb_wb_master_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic                  wb_clk = 1'b0;
  logic                  wb_rst_n;
  logic [NUM_REQ-1:0]    req_i, req_we_i;
  logic [NUM_REQ*AW-1:0] req_adr_i;
  logic [NUM_REQ*4-1:0]  req_sel_i;
  logic [NUM_REQ*DW-1:0] req_dat_i;
  logic [NUM_REQ-1:0]    gnt_o, done_o;
  logic [DW-1:0]         rsp_dat_o, m_data_wr_o, m_data_rd_i;
  logic                  busy_o, m_start_o, m_write_o, m_active_i;
  logic [AW-1:0]         m_address_o;
  logic [3:0]            m_selection_o;

  logic          slave_act, foreign_act;
  int            slave_len;
  logic [DW-1:0] slave_rdata;
  assign m_active_i = slave_act | foreign_act;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_master_arbiter #(.NUM_REQ(NUM_REQ), .aw(AW), .dw(DW)) dut (
    .wb_clk        (wb_clk),
    .wb_rst_n      (wb_rst_n),
    .req_i         (req_i),
    .req_adr_i     (req_adr_i),
    .req_sel_i     (req_sel_i),
    .req_we_i      (req_we_i),
    .req_dat_i     (req_dat_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .rsp_dat_o     (rsp_dat_o),
    .busy_o        (busy_o),
    .m_start_o     (m_start_o),
    .m_address_o   (m_address_o),
    .m_selection_o (m_selection_o),
    .m_write_o     (m_write_o),
    .m_data_wr_o   (m_data_wr_o),
    .m_data_rd_i   (m_data_rd_i),
    .m_active_i    (m_active_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #2;
  endtask

  // Reference model: which requester must win under the arbitration rule.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
`ifdef WB_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < NUM_REQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  // Transaction-level model: a transfer is either in flight or not; it
  // completes on the first edge with the master idle after it was seen busy
  // (the start cycle itself is not an observation point for busy).
  logic [NUM_REQ-1:0] e_gnt, e_done;
  logic               e_start, e_we, e_busy;
  logic [AW-1:0]      e_adr;
  logic [3:0]         e_sel;
  logic [DW-1:0]      e_wdat, e_rsp;
  int                 m_last, m_win, age;
  bit                 saw_busy;

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      e_gnt = '0; e_done = '0; e_start = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      e_adr = '0; e_sel = '0; e_wdat = '0; e_rsp = '0;
      m_last = NUM_REQ - 1; m_win = 0; age = 0; saw_busy = 1'b0;
    end else begin
      e_done  = '0;
      e_start = 1'b0;
      if (!e_busy) begin
        if (req_i != '0 && !m_active_i) begin
          m_win    = pick(req_i, m_last);
          m_last   = m_win;
          e_gnt    = '0;
          e_gnt[m_win] = 1'b1;
          e_adr    = req_adr_i[m_win*AW +: AW];
          e_sel    = req_sel_i[m_win*4 +: 4];
          e_we     = req_we_i[m_win];
          e_wdat   = req_dat_i[m_win*DW +: DW];
          e_start  = 1'b1;
          e_busy   = 1'b1;
          age      = 0;
          saw_busy = 1'b0;
        end
      end else begin
        age++;
        if (age >= 2) begin
          if (!saw_busy) saw_busy = m_active_i;
          else if (!m_active_i) begin
            if (!e_we) e_rsp = m_data_rd_i;
            e_done = e_gnt;
            e_gnt  = '0;
            e_busy = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge wb_clk) begin
    if (chk_en) begin
      chk("cyc_gnt",   64'(gnt_o),         64'(e_gnt));
      chk("cyc_done",  64'(done_o),        64'(e_done));
      chk("cyc_start", 64'(m_start_o),     64'(e_start));
      chk("cyc_busy",  64'(busy_o),        64'(e_busy));
      chk("cyc_we",    64'(m_write_o),     64'(e_we));
      chk("cyc_adr",   64'(m_address_o),   64'(e_adr));
      chk("cyc_sel",   64'(m_selection_o), 64'(e_sel));
      chk("cyc_wdat",  64'(m_data_wr_o),   64'(e_wdat));
      chk("cyc_rsp",   64'(rsp_dat_o),     64'(e_rsp));
    end
  end

  // Event recorder for the hand-computed expectations.
  int                 start_cnt = 0, done_cnt = 0, gnt_changes = 0;
  int                 grant_q[$];
  logic [NUM_REQ-1:0] prev_gnt = '0;

  always @(negedge wb_clk) begin
    if (m_start_o === 1'b1) start_cnt++;
    if (done_o != '0) done_cnt++;
    if (gnt_o != prev_gnt) begin
      gnt_changes++;
      for (int k = 0; k < NUM_REQ; k++) if (gnt_o[k]) grant_q.push_back(k);
    end
    prev_gnt = gnt_o;
  end

  function automatic int grant_at(input int i);
    return (grant_q.size() > i) ? grant_q[i] : -1;
  endfunction

  // Slave model: goes active the cycle after m_start_o, stays for slave_len cycles.
  initial begin
    slave_act   = 1'b0;
    m_data_rd_i = '0;
    forever begin
      tick();
      if (m_start_o === 1'b1) begin
        tick();
        slave_act   = 1'b1;
        m_data_rd_i = slave_rdata;
        repeat (slave_len) @(posedge wb_clk);
        #2;
        slave_act = 1'b0;
      end
    end
  end

  task automatic set_fields(input int idx, input logic [AW-1:0] adr, input logic [3:0] sel,
                            input logic we, input logic [DW-1:0] dat);
    req_adr_i[idx*AW +: AW] = adr;
    req_sel_i[idx*4 +: 4]   = sel;
    req_we_i[idx]           = we;
    req_dat_i[idx*DW +: DW] = dat;
  endtask

  // Waits for done_o[idx], then drops that request; n = edges from request to done.
  task automatic run_xfer(input int idx, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (done_o[idx]) break;
    end
    chk($sformatf("done_seen_%0d", idx), 64'(done_o[idx]), 64'd1);
    req_i[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  int n, s0, d0, g0, nexp;
  int exp_order[$];

  initial begin
    wb_rst_n = 1'b0; req_i = '0; req_we_i = '0; req_adr_i = '0; req_sel_i = '0;
    req_dat_i = '0; foreign_act = 1'b0; slave_len = 1; slave_rdata = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    chk("rst_gnt",  64'(gnt_o),       64'd0);
    chk("rst_busy", 64'(busy_o),      64'd0);
    chk("rst_adr",  64'(m_address_o), 64'd0);
    chk("rst_rsp",  64'(rsp_dat_o),   64'd0);
    wb_rst_n = 1'b1;
    tick();

    // Single read from requester 0, zero-wait slave
    set_fields(0, 32'h100, 4'hF, 1'b0, 32'h0);
    slave_rdata = 32'hDEADBEEF; slave_len = 1;
    s0 = start_cnt; d0 = done_cnt; grant_q.delete();
    req_i[0] = 1'b1;
    run_xfer(0, 50, n);
    tick();
    chk("read_latency", 64'(n + 1), 64'd5);
    chk("read_grant",   64'(grant_at(0)), 64'd0);
    chk("read_starts",  64'(start_cnt - s0), 64'd1);
    chk("read_dones",   64'(done_cnt - d0), 64'd1);
    chk("read_rsp",     64'(rsp_dat_o), 64'hDEADBEEF);

    // Write from requester 2; read data on the bus must not reach rsp_dat_o
    set_fields(2, 32'h200, 4'h3, 1'b1, 32'h12345678);
    slave_rdata = 32'hCAFEF00D;
    d0 = done_cnt; grant_q.delete();
    req_i[2] = 1'b1;
    run_xfer(2, 50, n);
    tick();
    chk("write_grant", 64'(grant_at(0)), 64'd2);
    chk("write_we",    64'(m_write_o), 64'd1);
    chk("write_dat",   64'(m_data_wr_o), 64'h12345678);
    chk("write_dones", 64'(done_cnt - d0), 64'd1);
    chk("write_rsp",   64'(rsp_dat_o), 64'hDEADBEEF);

    // Slave active for 10 cycles
    set_fields(1, 32'h140, 4'hC, 1'b0, 32'h0);
    slave_rdata = 32'h0BADF00D; slave_len = 10;
    s0 = start_cnt; d0 = done_cnt; g0 = gnt_changes;
    req_i[1] = 1'b1;
    run_xfer(1, 80, n);
    tick();
    chk("slow_latency", 64'(n + 1), 64'd14);
    chk("slow_starts",  64'(start_cnt - s0), 64'd1);
    chk("slow_dones",   64'(done_cnt - d0), 64'd1);
    chk("slow_gnt_chg", 64'(gnt_changes - g0), 64'd2);
    chk("slow_rsp",     64'(rsp_dat_o), 64'h0BADF00D);

    // Requester 3 drops req and alters its fields after grant
    set_fields(3, 32'h300, 4'h1, 1'b0, 32'h0);
    slave_rdata = 32'h33333333; slave_len = 3;
    d0 = done_cnt;
    req_i[3] = 1'b1;
    n = 0;
    while (!gnt_o[3] && n < 20) begin tick(); n++; end
    chk("drop_gnt", 64'(gnt_o[3]), 64'd1);
    req_i[3] = 1'b0;
    set_fields(3, 32'h3FF, 4'hF, 1'b1, 32'hFFFFFFFF);
    n = 0;
    while (!done_o[3] && n < 40) begin tick(); n++; end
    chk("drop_done", 64'(done_o[3]), 64'd1);
    tick();
    chk("drop_adr",   64'(m_address_o), 64'h300);
    chk("drop_we",    64'(m_write_o), 64'd0);
    chk("drop_dones", 64'(done_cnt - d0), 64'd1);

    // Foreign activity blocks granting
    set_fields(1, 32'h110, 4'hF, 1'b0, 32'h0);
    slave_rdata = 32'h11110000; slave_len = 1;
    foreign_act = 1'b1;
    s0 = start_cnt; d0 = done_cnt; grant_q.delete();
    req_i = 4'b0010;
    repeat (6) tick();
    chk("foreign_gnt",    64'(gnt_o), 64'd0);
    chk("foreign_busy",   64'(busy_o), 64'd0);
    chk("foreign_starts", 64'(start_cnt - s0), 64'd0);
    foreign_act = 1'b0;
    run_xfer(1, 50, n);
    tick();
    chk("foreign_latency", 64'(n + 1), 64'd5);
    chk("foreign_grant",   64'(grant_at(0)), 64'd1);
    chk("foreign_dones",   64'(done_cnt - d0), 64'd1);

    // All requesters held high from reset
    wb_rst_n = 1'b0;
    repeat (2) tick();
    wb_rst_n = 1'b1;
    tick();
    for (int k = 0; k < NUM_REQ; k++) set_fields(k, 32'h1000 + 32'(k * 16), 4'hF, 1'b0, 32'h0);
    slave_rdata = 32'h5A5A5A5A; slave_len = 1;
`ifdef WB_ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    nexp = exp_order.size();
    grant_q.delete();
    req_i = 4'b1111;
    n = 0;
    while (grant_q.size() < nexp && n < 300) begin tick(); n++; end
    req_i = '0;
    n = 0;
    while (busy_o && n < 50) begin tick(); n++; end
    tick();
    chk("order_count", 64'(grant_q.size()), 64'(nexp));
    for (int k = 0; k < nexp; k++) chk($sformatf("order_%0d", k), 64'(grant_at(k)), 64'(exp_order[k]));

    // Reset in WAIT_DONE, then requesters 0 and 2 contend
    set_fields(0, 32'h500, 4'hF, 1'b0, 32'h0);
    slave_rdata = 32'h77777777; slave_len = 10;
    req_i = 4'b0001;
    n = 0;
    while (!gnt_o[0] && n < 20) begin tick(); n++; end
    repeat (4) tick();
    chk("rst_mid_active", 64'(m_active_i), 64'd1);
    d0 = done_cnt;
    #1 wb_rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt",   64'(gnt_o), 64'd0);
    chk("rst_mid_done",  64'(done_o), 64'd0);
    chk("rst_mid_start", 64'(m_start_o), 64'd0);
    chk("rst_mid_busy",  64'(busy_o), 64'd0);
    chk("rst_mid_adr",   64'(m_address_o), 64'd0);
    chk("rst_mid_rsp",   64'(rsp_dat_o), 64'd0);
    req_i = '0;
    repeat (2) tick();
    chk("rst_mid_nodone", 64'(done_cnt - d0), 64'd0);
    wb_rst_n = 1'b1;
    set_fields(2, 32'h520, 4'hF, 1'b0, 32'h0);
    slave_len = 1;
    grant_q.delete();
    req_i = 4'b0101;
    run_xfer(0, 80, n);
    run_xfer(2, 80, n);
    tick();
    chk("rst_first_grant",  64'(grant_at(0)), 64'd0);
    chk("rst_second_grant", 64'(grant_at(1)), 64'd2);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
